// File: rtl/lfsr_rng_source.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_rng_source
//  Purpose  : 32-bit Galois LFSR that pushes one word every 32 steps into a
//             first-word-fall-through FIFO and stalls while the FIFO is full.
//             Define LFSR_WHITEN_EN to push s ^ {s[15:0], s[31:16]} instead of s.
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr_rng_source #(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iSeedWrite,
    input  logic [31:0]              iSeed,
    input  logic                     iPop,
    output logic [31:0]              oData,
    output logic                     oValid,
    output logic                     oFull,
    output logic [$clog2(DEPTH):0]   oCount
);

    localparam int                PTR_W       = $clog2(DEPTH);
    localparam int                CNT_W       = PTR_W + 1;
    localparam logic [31:0]       c_POLY      = 32'h8020_0003;
    localparam logic [CNT_W-1:0]  c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [0:0]        c_RUN       = 1'b0;
    localparam logic [0:0]        c_STALL     = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_stateNext;
    logic [31:0]      r_lfsr;
    logic [31:0]      w_lfsrStep;
    logic [31:0]      w_pushWord;
    logic [4:0]       r_step;
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_countNext;
    logic [31:0]      r_mem [DEPTH];
    logic             w_run;
    logic             w_push;
    logic             w_pop;

    assign w_lfsrStep = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_POLY : 32'h0);

`ifdef LFSR_WHITEN_EN
    assign w_pushWord = w_lfsrStep ^ {w_lfsrStep[15:0], w_lfsrStep[31:16]};
`else
    assign w_pushWord = w_lfsrStep;
`endif

    // State register
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state: STALL exactly when the FIFO will hold DEPTH words
    always_comb begin
        w_stateNext = c_RUN;
        if (!iSeedWrite && (w_countNext == c_DEPTH_CNT)) begin
            w_stateNext = c_STALL;
        end
    end

    // Per-state controls; a seed write pre-empts stepping, pushing and popping
    always_comb begin
        w_run  = (r_state == c_RUN) && !iSeedWrite;
        w_push = w_run && (r_step == 5'd31);
        w_pop  = iPop && oValid && !iSeedWrite;
    end

    always_comb begin
        w_countNext = r_count;
        if (w_push && !w_pop) begin
            w_countNext = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_lfsr  <= SEED_DEFAULT;
            r_step  <= 5'd0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (iSeedWrite) begin
            r_lfsr  <= (iSeed == 32'h0) ? SEED_DEFAULT : iSeed;
            r_step  <= 5'd0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_run) begin
                r_lfsr <= w_lfsrStep;
                r_step <= r_step + 5'd1;
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_count <= w_countNext;
        end
    end

    // Storage needs no reset: oData is gated by occupancy
    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_pushWord;
        end
    end

    assign oValid = (r_count != '0);
    assign oFull  = (r_count == c_DEPTH_CNT);
    assign oCount = r_count;
    assign oData  = oValid ? r_mem[r_rdPtr] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_rng_source.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_rng_source
//  Purpose  : Directed and randomized checks of lfsr_rng_source against a
//             queue-based word-stream model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_rng_source;

    localparam int          DEPTH = 4;
    localparam logic [31:0] SEED  = 32'h0000_0001;
    localparam int          CW    = $clog2(DEPTH) + 1;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic          iSeedWrite = 1'b0;
    logic [31:0]   iSeed = 32'h0;
    logic          iPop = 1'b0;
    logic [31:0]   oData;
    logic          oValid;
    logic          oFull;
    logic [CW-1:0] oCount;

    int nChecks = 0;
    int nPass   = 0;

    // Reference model: current LFSR value, steps since last word, queued words
    logic [31:0] mLfsr;
    int          mPhase;
    logic [31:0] mQ[$];

    lfsr_rng_source #(.DEPTH(DEPTH), .SEED_DEFAULT(SEED)) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iSeedWrite(iSeedWrite),
        .iSeed     (iSeed),
        .iPop      (iPop),
        .oData     (oData),
        .oValid    (oValid),
        .oFull     (oFull),
        .oCount    (oCount)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [31:0] galois(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] stepN(input logic [31:0] s, input int n);
        logic [31:0] v = s;
        for (int i = 0; i < n; i++) v = galois(v);
        return v;
    endfunction

    function automatic logic [31:0] whiten(input logic [31:0] s);
`ifdef LFSR_WHITEN_EN
        return s ^ {s[15:0], s[31:16]};
`else
        return s;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic checkOutputs(input string tag);
        int sz = mQ.size();
        check({tag, "_valid"}, 32'(oValid), 32'(sz > 0));
        check({tag, "_count"}, 32'(oCount), 32'(sz));
        check({tag, "_full"},  32'(oFull),  32'(sz == DEPTH));
        check({tag, "_data"},  oData,       (sz > 0) ? mQ[0] : 32'h0);
    endtask

    task automatic cycle(input logic sw, input logic [31:0] sd, input logic pp);
        iSeedWrite = sw;
        iSeed      = sd;
        iPop       = pp;
        @(posedge iCLK);
        if (sw) begin
            mLfsr  = (sd == 32'h0) ? SEED : sd;
            mPhase = 0;
            mQ.delete();
        end else begin
            int sz = mQ.size();
            if (pp && sz > 0) void'(mQ.pop_front());
            if (sz < DEPTH) begin
                mLfsr  = galois(mLfsr);
                mPhase = (mPhase + 1) % 32;
                if (mPhase == 0) mQ.push_back(whiten(mLfsr));
            end
        end
        #1;
        checkOutputs("cyc");
    endtask

    task automatic resetCycle(input logic sw, input logic [31:0] sd, input logic pp);
        iRST       = 1'b1;
        iSeedWrite = sw;
        iSeed      = sd;
        iPop       = pp;
        @(posedge iCLK);
        mLfsr  = SEED;
        mPhase = 0;
        mQ.delete();
        #1;
        iRST       = 1'b0;
        iSeedWrite = 1'b0;
        iPop       = 1'b0;
        checkOutputs("reset");
    endtask

    initial begin
        logic [31:0] sd;

        // Reset overrides a concurrent seed write and pop
        resetCycle(1'b1, 32'h1234_5678, 1'b1);
        check("reset_data", oData, 32'h0);

        // First word appears on edge 32
        repeat (31) cycle(1'b0, 32'h0, 1'b0);
        check("first_not_yet", 32'(oValid), 32'd0);
        cycle(1'b0, 32'h0, 1'b0);
        check("first_word", oData, whiten(stepN(SEED, 32)));
        check("first_count", 32'(oCount), 32'd1);

        // Fill, then hold in stall
        repeat (96) cycle(1'b0, 32'h0, 1'b0);
        check("fill_count", 32'(oCount), 32'd4);
        check("fill_full", 32'(oFull), 32'd1);
        repeat (50) cycle(1'b0, 32'h0, 1'b0);
        check("hold_data", oData, whiten(stepN(SEED, 32)));
        check("hold_count", 32'(oCount), 32'd4);

        // One pop: next push exactly 32 edges later
        cycle(1'b0, 32'h0, 1'b1);
        check("pop_count", 32'(oCount), 32'd3);
        check("pop_head", oData, whiten(stepN(SEED, 64)));
        repeat (31) cycle(1'b0, 32'h0, 1'b0);
        check("pop_wait_count", 32'(oCount), 32'd3);
        cycle(1'b0, 32'h0, 1'b0);
        check("pop_refill_count", 32'(oCount), 32'd4);

        // Zero seed falls back to the default stream
        cycle(1'b1, 32'h0, 1'b1);
        check("flush_valid", 32'(oValid), 32'd0);
        repeat (32) cycle(1'b0, 32'h0, 1'b0);
        check("reseed_word", oData, whiten(stepN(SEED, 32)));
        repeat (32) cycle(1'b0, 32'h0, 1'b0);
        check("two_words", 32'(oCount), 32'd2);

        // Seed write with concurrent pop at occupancy 2
        sd = $urandom;
        if (sd == 32'h0) sd = 32'h1;
        cycle(1'b1, sd, 1'b1);
        check("seedpop_count", 32'(oCount), 32'd0);
        repeat (32) cycle(1'b0, 32'h0, 1'b0);
        check("seedpop_word", oData, whiten(stepN(sd, 32)));

        // Continuous pop from seed DEADBEEF
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
        for (int w = 1; w <= 10; w++) begin
            repeat (31) cycle(1'b0, 32'h0, 1'b1);
            check("stream_empty", 32'(oCount), 32'd0);
            cycle(1'b0, 32'h0, 1'b1);
            check("stream_count", 32'(oCount), 32'd1);
            check("stream_word", oData, whiten(stepN(32'hDEAD_BEEF, 32 * w)));
        end

        // Randomized pops and occasional reseeds
        for (int i = 0; i < 3000; i++) begin
            logic rsw;
            logic rpp;
            logic [31:0] rsd;
            rsw = ($urandom_range(0, 499) == 0);
            rsd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            rpp = (i < 1500) ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 7) == 0);
            cycle(rsw, rsd, rpp);
        end

        // Reset mid-accumulation at step 17 with two words queued
        resetCycle(1'b0, 32'h0, 1'b0);
        repeat (64 + 17) cycle(1'b0, 32'h0, 1'b0);
        check("midrst_count_before", 32'(oCount), 32'd2);
        resetCycle(1'($urandom_range(0, 1)), $urandom, 1'b1);
        check("midrst_count", 32'(oCount), 32'd0);
        check("midrst_valid", 32'(oValid), 32'd0);
        check("midrst_data", oData, 32'h0);
        repeat (31) cycle(1'b0, 32'h0, 1'b0);
        check("midrst_not_yet", 32'(oValid), 32'd0);
        cycle(1'b0, 32'h0, 1'b0);
        check("midrst_word", oData, whiten(stepN(SEED, 32)));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
